// File: rtl/veri_risc_pkg.sv
// Shared definitions for the parametrised VeriRISC core: opcodes, phase/halt
// state encoding and the ALU-op classifier.
package veri_risc_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Low three bits of a phase state are the externally visible phase number.
    typedef enum logic [3:0] {
        PH_INST_ADDR  = 4'd0,
        PH_INST_FETCH = 4'd1,
        PH_INST_LOAD  = 4'd2,
        PH_IDLE       = 4'd3,
        PH_OP_ADDR    = 4'd4,
        PH_OP_FETCH   = 4'd5,
        PH_ALU_OP     = 4'd6,
        PH_STORE      = 4'd7,
        ST_HALT       = 4'd8
    } state_t;

    localparam logic [2:0] HALT_PHASE_OUT = 3'd4;

    function automatic logic is_alu_op(input logic [2:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_alu_p.sv
// Combinational accumulator ALU; zero flags an all-zero accumulator for SKZ.
module risc_alu_p
    import veri_risc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] ac,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    always_comb begin
        result = ac;
        case (opcode)
            OP_ADD:  result = ac + rdata;
            OP_AND:  result = ac & rdata;
            OP_XOR:  result = ac ^ rdata;
            OP_LDA:  result = rdata;
            default: result = ac;
        endcase
    end

    assign zero = (ac == '0);

endmodule

// File: rtl/veri_risc_core_p.sv
// Parametrised 8-phase VeriRISC core with external registered memory port,
// single-step and resume-from-halt. Optional macro: RISC_INSTR_CNT_EN.
module veri_risc_core_p
    import veri_risc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  halt,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
`ifdef RISC_INSTR_CNT_EN
    output logic [31:0]           instr_cnt,
`endif
    output logic [2:0]            phase_out
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] r_ac;
    logic [DATA_WIDTH-1:0] w_ac_next;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] w_ir_next;

    logic [2:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_zero;
    logic                  w_ir_unused;

    assign w_opcode  = r_ir[DATA_WIDTH-1 -: 3];
    assign w_operand = r_ir[ADDR_WIDTH-1:0];
    assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
    // Bits between operand and opcode carry no meaning.
    assign w_ir_unused = ^r_ir;

    risc_alu_p #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .opcode(w_opcode),
        .ac    (r_ac),
        .rdata (mem_rdata),
        .result(w_alu_result),
        .zero  (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PH_INST_ADDR;
            r_pc    <= '0;
            r_ac    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ac    <= w_ac_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ac_next    = r_ac;
        w_ir_next    = r_ir;
        mem_addr     = r_pc;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        case (r_state)
            PH_INST_ADDR: begin
                if (!step_mode || step) w_state_next = PH_INST_FETCH;
            end
            PH_INST_FETCH: begin
                mem_rd       = 1'b1;
                w_state_next = PH_INST_LOAD;
            end
            PH_INST_LOAD: begin
                w_ir_next    = mem_rdata;
                w_state_next = PH_IDLE;
            end
            PH_IDLE: w_state_next = PH_OP_ADDR;
            PH_OP_ADDR: begin
                w_pc_next    = w_pc_inc;
                w_state_next = (w_opcode == OP_HLT) ? ST_HALT : PH_OP_FETCH;
            end
            PH_OP_FETCH: begin
                mem_addr     = w_operand;
                mem_rd       = is_alu_op(w_opcode);
                w_state_next = PH_ALU_OP;
            end
            PH_ALU_OP: begin
                mem_addr = w_operand;
                if (is_alu_op(w_opcode)) w_ac_next = w_alu_result;
                if (w_opcode == OP_SKZ && w_alu_zero) w_pc_next = w_pc_inc;
                if (w_opcode == OP_JMP) w_pc_next = w_operand;
                if (w_opcode == OP_STO) mem_wr = 1'b1;
                w_state_next = PH_STORE;
            end
            PH_STORE: begin
                mem_addr     = w_operand;
                w_state_next = PH_INST_ADDR;
            end
            ST_HALT: begin
                if (resume) w_state_next = PH_INST_ADDR;
            end
            default: w_state_next = PH_INST_ADDR;
        endcase
    end

    assign halt      = (r_state == ST_HALT);
    assign phase_out = halt ? HALT_PHASE_OUT : r_state[2:0];
    assign mem_wdata = r_ac;
    assign ac_out    = r_ac;
    assign pc_out    = r_pc;

`ifdef RISC_INSTR_CNT_EN
    logic [31:0] r_instr_cnt;

    // PH_STORE always falls through to phase 0, so this counts completed non-HLT instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_instr_cnt <= '0;
        else if (r_state == PH_STORE) r_instr_cnt <= r_instr_cnt + 32'd1;
    end

    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: doc/veri_risc_core_p.md
Name: veri_risc_core_p

Overview:
Parametrised next-generation VeriRISC core: an 8-phase multi-cycle fetch/execute machine with generic data and address widths.
- Instruction memory and data memory are external, on a registered single-port interface instead of an internal memory and tri-state bus.
- Adds single-step and resume-from-halt control.
- Sits between the system top and a synchronous RAM model; replaces the fixed 8-bit/5-bit core.

Parameters:
DATA_WIDTH, 8, accumulator, ALU and memory word width; must be >= ADDR_WIDTH+3.
ADDR_WIDTH, 5, PC and operand address width; the PC wraps modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
step_mode  input  1  1 = pause at phase 0 until step.
step  input  1  one-cycle pulse that releases one instruction in step mode.
resume  input  1  one-cycle pulse that leaves HALT.
mem_addr  output  ADDR_WIDTH  memory address.
mem_rd  output  1  read strobe; data is returned on mem_rdata the next cycle.
mem_rdata  input  DATA_WIDTH  read data.
mem_wr  output  1  write strobe; the memory writes mem_wdata on this rising edge.
mem_wdata  output  DATA_WIDTH  write data (= ac).
halt  output  1  core halted.
ac_out  output  DATA_WIDTH  accumulator (debug).
pc_out  output  ADDR_WIDTH  program counter.
phase_out  output  3  current phase.

Behaviour:
- Reset (rst=0, asynchronous): pc=0, ac=0, ir=0, phase=0, halted=0. All outputs are 0.
- Instruction format: opcode = ir[DATA_WIDTH-1 -: 3]; operand = ir[ADDR_WIDTH-1:0]; middle bits are ignored.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALU-op set = {ADD, AND, XOR, LDA}.
- Phases advance by 1 per clock, 0..7, then wrap to 0.
- Phase 0 INST_ADDR: mem_addr=pc.
  - If step_mode=1, stay in phase 0 until step=1.
  - step is ignored in every other phase.
- Phase 1 INST_FETCH: mem_addr=pc, mem_rd=1.
- Phase 2 INST_LOAD: ir <= mem_rdata.
- Phase 3 IDLE: no action.
- Phase 4 OP_ADDR: pc <= pc+1 (wraps).
  - If opcode==HLT, go to the HALT state instead of phase 5.
- Phase 5 OP_FETCH: mem_addr=operand; mem_rd=1 if ALU-op.
- Phase 6 ALU_OP:
  - mem_addr=operand.
  - ALU-op: ac <= ac+rdata (ADD, carry discarded, mod 2^DATA_WIDTH), ac&rdata (AND), ac^rdata (XOR), or rdata (LDA).
  - SKZ: if ac==0, pc <= pc+1 (wraps).
  - JMP: pc <= operand.
  - STO: mem_wr=1, mem_wdata=ac.
- Phase 7 STORE: no action; next phase is 0.
- HALT state: halt=1, phase_out=4, mem_rd=0, mem_wr=0, pc holds.
  - resume=1 returns the core to phase 0 on the next edge, continuing at the already-incremented pc.
  - resume is ignored when not halted.
  - step has no effect in HALT.
- Cycle count: each instruction takes 8 cycles when not paused.
- mem_wdata equals ac at all times; only mem_wr qualifies it.
- Reset mid-instruction aborts it immediately; an in-flight STO does not write.

Optional Feature:
RISC_INSTR_CNT_EN:
- Defined: adds output instr_cnt [31:0]. It resets to 0, increments on every phase-7→0 transition, excludes HLT, and wraps at 2^32.
- Undefined: the port and counter are absent.

Decomposition:
- Package veri_risc_pkg holds:
  - the opcode localparams (3-bit);
  - the phase encoding constants PH_INST_ADDR..PH_STORE;
  - the HALT state encoding;
  - the function is_alu_op(opcode).
- One sub-module, risc_alu_p: combinational, parametrised by DATA_WIDTH; inputs opcode, ac, rdata; outputs result and zero.
- Sequencing, PC and IR stay in veri_risc_core_p.

Test Plan:
- Basic program, default widths. mem[0]=0xB0 (LDA 0x10), [1]=0x51 (ADD 0x11), [2]=0xD2 (STO 0x12), [3]=0x00 (HLT); mem[0x10]=0x05, [0x11]=0x03.
  - Required: mem[0x12]=0x08; halt rises on the 29th edge after reset release; pc_out=4; ac_out=0x08.
- SKZ. ac=0, program SKZ; JMP 0x1F; LDA 0x10.
  - Required: the JMP is skipped, ac=0x05, pc never equals 0x1F.
  - Repeat with ac=1: pc becomes 0x1F.
- PC wrap. JMP 0x1F, with mem[0x1F]=XOR 0x10.
  - Required: after the XOR, pc_out=0x00 and ac=ac^0x05.
- Step mode. step_mode=1.
  - Required: phase_out stays 0 for 20 cycles with no mem_rd.
  - One step pulse executes exactly one instruction (8 cycles), then the core pauses again at phase 0.
- Resume and reset. After HLT, pulse resume: execution continues at the HLT address+1.
  - Separately, drive rst=0 during phase 6 of STO: mem_wr drops immediately, memory is unchanged, and all outputs return to reset values.
- Wide configuration. DATA_WIDTH=16, ADDR_WIDTH=8: LDA 0x80 (0xFFFF), then ADD 0x81 (0x0002).
  - Required: ac=0x0001 (carry discarded).
  - With RISC_INSTR_CNT_EN defined: instr_cnt=2.
